bus_mux_reg: RTL and testbench

//   Parametrised N-input, W-bit bus multiplexer with one-hot select and a

---
 rtl/bus_mux_reg.sv | 156 +++++++++++++++
 tb/tb_bus_mux_reg.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bus_mux_reg.sv
// bus_mux_reg: N-input, W-bit bus multiplexer with one-hot select feeding a
// registered 2-entry skid buffer with valid/ready flow control.
// Optional build macro: BUSMUX_PRIO_EN.
//   Defined:   SEL is priority-decoded (lowest set bit wins); only zero-hot is an error.
//   Undefined: strict one-hot decode; zero-hot and multi-hot are errors.
module bus_mux_reg #(
    parameter int WIDTH  = 9,
    parameter int NUM_IN = 10
) (
    input  logic                    CLK,
    input  logic                    RESETN,
    input  logic [NUM_IN*WIDTH-1:0] IN_BUS,
    input  logic [NUM_IN-1:0]       SEL,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    output logic [WIDTH-1:0]        OUT,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic                    SEL_ERR
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL1 = 2'd1,
        ST_FULL2 = 2'd2
    } state_t;

    // Returns {err, data}. A bad select always yields zero data with err set.
    function automatic logic [WIDTH:0] decode_sel(
        input logic [NUM_IN*WIDTH-1:0] bus,
        input logic [NUM_IN-1:0]       sel
    );
        logic [WIDTH-1:0] data;
        logic             found;
        logic             multi;
        logic             err;
        data  = {WIDTH{1'b0}};
        found = 1'b0;
        multi = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel[k] && found) begin
                multi = 1'b1;
            end else if (sel[k]) begin
                found = 1'b1;
                data  = bus[k*WIDTH +: WIDTH];
            end else begin
                multi = multi;
            end
        end
`ifdef BUSMUX_PRIO_EN
        // Lowest-index set bit already captured; multi-hot is legal.
        err = ~found;
`else
        err = ~found | multi;
`endif
        if (err) begin
            decode_sel = {1'b1, {WIDTH{1'b0}}};
        end else begin
            decode_sel = {1'b0, data};
        end
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             err_q, err_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             skid_err_q, skid_err_d;

    logic             accept_s;
    logic             emit_s;
    logic [WIDTH:0]   dec_s;

    assign accept_s = IN_VALID & in_ready_q;
    assign emit_s   = out_valid_q & OUT_READY;
    assign dec_s    = decode_sel(IN_BUS, SEL);

    // Next-state and datapath load selection for the two-entry buffer.
    always_comb begin
        state_d    = state_q;
        out_d      = out_q;
        err_d      = err_q;
        skid_d     = skid_q;
        skid_err_d = skid_err_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_d = ST_FULL1;
                    out_d   = dec_s[WIDTH-1:0];
                    err_d   = dec_s[WIDTH];
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL1: begin
                if (accept_s && !emit_s) begin
                    state_d    = ST_FULL2;
                    skid_d     = dec_s[WIDTH-1:0];
                    skid_err_d = dec_s[WIDTH];
                end else if (accept_s && emit_s) begin
                    state_d = ST_FULL1;
                    out_d   = dec_s[WIDTH-1:0];
                    err_d   = dec_s[WIDTH];
                end else if (emit_s) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_FULL1;
                end
            end
            ST_FULL2: begin
                // IN_READY is low here, so only the drain path exists.
                if (emit_s) begin
                    state_d = ST_FULL1;
                    out_d   = skid_q;
                    err_d   = skid_err_q;
                end else begin
                    state_d = ST_FULL2;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        // Flags derived from next state so they are ready the cycle it takes effect.
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL2);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q     <= ST_EMPTY;
            out_q       <= {WIDTH{1'b0}};
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            skid_q      <= {WIDTH{1'b0}};
            skid_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            skid_q      <= skid_d;
            skid_err_q  <= skid_err_d;
        end
    end

    assign OUT       = out_q;
    assign SEL_ERR   = err_q;
    assign OUT_VALID = out_valid_q;
    assign IN_READY  = in_ready_q;

endmodule

// File: tb/tb_bus_mux_reg.sv
// tb_bus_mux_reg: directed-vector bench for bus_mux_reg with hand-computed expectations.
module tb_bus_mux_reg;

    localparam int W = 9;
    localparam int N = 10;

    logic             clk_s;
    logic             resetn_s;
    logic [N*W-1:0]   in_bus_s;
    logic [N-1:0]     sel_s;
    logic             in_valid_s;
    logic             in_ready_s;
    logic [W-1:0]     out_s;
    logic             out_valid_s;
    logic             out_ready_s;
    logic             sel_err_s;

    int n_cmp;
    int n_bad;

    bus_mux_reg #(.WIDTH(W), .NUM_IN(N)) dut (
        .CLK       (clk_s),
        .RESETN    (resetn_s),
        .IN_BUS    (in_bus_s),
        .SEL       (sel_s),
        .IN_VALID  (in_valid_s),
        .IN_READY  (in_ready_s),
        .OUT       (out_s),
        .OUT_VALID (out_valid_s),
        .OUT_READY (out_ready_s),
        .SEL_ERR   (sel_err_s)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk_s = 1'b0;
        forever #5 clk_s = ~clk_s;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle before sampling.
    task automatic step();
        @(posedge clk_s);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [W-1:0] v);
        in_bus_s[k*W +: W] = v;
    endtask

    task automatic check_out(input string tag, input logic [W-1:0] d, input logic v, input logic e);
        check_val({tag, "_out"},   32'(out_s),       32'(d));
        check_val({tag, "_valid"}, 32'(out_valid_s), 32'(v));
        check_val({tag, "_err"},   32'(sel_err_s),   32'(e));
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        resetn_s    = 1'b0;
        in_bus_s    = '0;
        sel_s       = 10'b0;
        in_valid_s  = 1'b0;
        out_ready_s = 1'b0;

        // 1. Reset
        step();
        step();
        check_out("reset", 9'h000, 1'b0, 1'b0);
        check_val("reset_in_ready", 32'(in_ready_s), 32'd1);
        resetn_s = 1'b1;
        step();
        check_val("idle_valid", 32'(out_valid_s), 32'd0);

        // 2. Single beat
        set_ch(3, 9'h0A5);
        sel_s       = 10'b0000001000;
        in_valid_s  = 1'b1;
        out_ready_s = 1'b1;
        step();
        in_valid_s = 1'b0;
        sel_s      = 10'b0;
        check_out("single", 9'h0A5, 1'b1, 1'b0);
        step();
        check_val("single_drain_valid", 32'(out_valid_s), 32'd0);

        // 3. Backpressure
        out_ready_s = 1'b0;
        set_ch(0, 9'h001);
        set_ch(1, 9'h002);
        set_ch(2, 9'h003);
        sel_s      = 10'b0000000001;
        in_valid_s = 1'b1;
        step();
        check_out("bp_b1", 9'h001, 1'b1, 1'b0);
        check_val("bp_rdy_b1", 32'(in_ready_s), 32'd1);
        sel_s = 10'b0000000010;
        step();
        check_val("bp_rdy_b2", 32'(in_ready_s), 32'd0);
        check_out("bp_hold1", 9'h001, 1'b1, 1'b0);
        sel_s = 10'b0000000100;
        step();
        check_val("bp_rdy_b3", 32'(in_ready_s), 32'd0);
        check_out("bp_hold2", 9'h001, 1'b1, 1'b0);
        out_ready_s = 1'b1;
        step();
        check_out("bp_o2", 9'h002, 1'b1, 1'b0);
        check_val("bp_rdy_o2", 32'(in_ready_s), 32'd1);
        step();
        in_valid_s = 1'b0;
        sel_s      = 10'b0;
        check_out("bp_o3", 9'h003, 1'b1, 1'b0);
        step();
        check_val("bp_drain_valid", 32'(out_valid_s), 32'd0);

        // 4. Streaming: channel k carries 16*k+5
        for (int k = 0; k < N; k++) begin
            set_ch(k, 9'(16 * k + 5));
        end
        in_valid_s = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sel_s = 10'b0;
            sel_s[i % N] = 1'b1;
            step();
            check_out($sformatf("stream%0d", i), 9'(16 * (i % N) + 5), 1'b1, 1'b0);
            check_val($sformatf("stream%0d_rdy", i), 32'(in_ready_s), 32'd1);
        end
        in_valid_s = 1'b0;
        sel_s      = 10'b0;
        step();
        check_val("stream_drain_valid", 32'(out_valid_s), 32'd0);

        // 5. Illegal select
        set_ch(1, 9'h1FF);
        sel_s      = 10'b0;
        in_valid_s = 1'b1;
        step();
        check_out("zerohot", 9'h000, 1'b1, 1'b1);
        sel_s = 10'b0000000110;
        step();
`ifdef BUSMUX_PRIO_EN
        check_out("multihot", 9'h1FF, 1'b1, 1'b0);
`else
        check_out("multihot", 9'h000, 1'b1, 1'b1);
`endif
        in_valid_s = 1'b0;
        sel_s      = 10'b1111111111;
        step();
        check_val("ignored_valid", 32'(out_valid_s), 32'd0);

        // 6. Mid-reset from FULL2
        out_ready_s = 1'b0;
        sel_s       = 10'b0000000001;
        in_valid_s  = 1'b1;
        step();
        step();
        check_val("mr_full2_rdy", 32'(in_ready_s), 32'd0);
        resetn_s = 1'b0;
        step();
        check_val("mr_valid", 32'(out_valid_s), 32'd0);
        check_val("mr_rdy", 32'(in_ready_s), 32'd1);
        resetn_s    = 1'b1;
        out_ready_s = 1'b1;
        set_ch(2, 9'h055);
        sel_s = 10'b0000000100;
        step();
        in_valid_s = 1'b0;
        sel_s      = 10'b0;
        check_out("mr_beat", 9'h055, 1'b1, 1'b0);
        step();
        check_val("mr_alone_valid", 32'(out_valid_s), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
